vscale_hpm_counter_bank: RTL and testbench

//  Parametrised bank of N_CNT event counters, each CNT_WIDTH bits wide, exposed as CSRs next to the core CSR file.

---
 rtl/vscale_hpm_counter_bank.sv | 230 +++++++++++++++++++++++
 tb/tb_vscale_hpm_counter_bank.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_hpm_counter_bank.sv
// Bank of event counters with compare/overflow pending bits, exposed as CSRs
// to the core and to a debug host through a valid/ready port.
module vscale_hpm_counter_bank #(
    parameter int                    XLEN       = 32,
    parameter int                    CNT_WIDTH  = 64,
    parameter int                    N_CNT      = 4,
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] CNT_BASE   = 12'hB00,
    parameter logic [ADDR_WIDTH-1:0] CNTH_BASE  = 12'hB80,
    parameter logic [ADDR_WIDTH-1:0] CMP_BASE   = 12'h7D0,
    parameter logic [ADDR_WIDTH-1:0] CTRL_ADDR  = 12'h7E0,
    parameter logic [ADDR_WIDTH-1:0] PEND_ADDR  = 12'h7E1,
    parameter logic [ADDR_WIDTH-1:0] IE_ADDR    = 12'h7E2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [1:0]            cmd,
    input  logic [XLEN-1:0]       wdata,
    output logic [XLEN-1:0]       rdata,
    output logic                  hit,
    input  logic [N_CNT-1:0]      event_inc,
    output logic [N_CNT-1:0]      irq,
    output logic                  irq_any,
    input  logic                  host_req_valid,
    output logic                  host_req_ready,
    input  logic                  host_req_rw,
    input  logic [ADDR_WIDTH-1:0] host_req_addr,
    input  logic [XLEN-1:0]       host_req_data,
    output logic                  host_resp_valid,
    input  logic                  host_resp_ready,
    output logic [XLEN-1:0]       host_resp_data
);

    localparam int HW = CNT_WIDTH - XLEN;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    logic [CNT_WIDTH-1:0] r_cnt [N_CNT];
    logic [XLEN-1:0]      r_cmp [N_CNT];
    logic [N_CNT-1:0]     r_inh;
    logic [N_CNT-1:0]     r_pm;
    logic [N_CNT-1:0]     r_po;
    logic [N_CNT-1:0]     r_iem;
    logic [N_CNT-1:0]     r_ieo;
    state_t               r_state;
    state_t               w_state_n;
    logic [XLEN-1:0]      r_resp_data;

    // Pending and enable share one layout: match low, overflow from bit 16
    function automatic logic [XLEN-1:0] f_pack(
        input logic [N_CNT-1:0] m,
        input logic [N_CNT-1:0] o
    );
        logic [XLEN-1:0] p;
        p = '0;
        p[N_CNT-1:0] = m;
        p[16 +: N_CNT] = o;
        return p;
    endfunction

    function automatic logic [XLEN-1:0] f_read(input logic [ADDR_WIDTH-1:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        for (int i = 0; i < N_CNT; i++) begin
            if (a == CNT_BASE + ADDR_WIDTH'(i))
                v = r_cnt[i][XLEN-1:0];
            if (a == CNTH_BASE + ADDR_WIDTH'(i))
                v = XLEN'(r_cnt[i][CNT_WIDTH-1:XLEN]);
            if (a == CMP_BASE + ADDR_WIDTH'(i))
                v = r_cmp[i];
        end
        if (a == CTRL_ADDR) v = XLEN'(r_inh);
        if (a == PEND_ADDR) v = f_pack(r_pm, r_po);
        if (a == IE_ADDR)   v = f_pack(r_iem, r_ieo);
        return v;
    endfunction

    function automatic logic f_hit(input logic [ADDR_WIDTH-1:0] a);
        logic h;
        h = (a == CTRL_ADDR) || (a == PEND_ADDR) || (a == IE_ADDR);
        for (int i = 0; i < N_CNT; i++) begin
            if (a == CNT_BASE + ADDR_WIDTH'(i))  h = 1'b1;
            if (a == CNTH_BASE + ADDR_WIDTH'(i)) h = 1'b1;
            if (a == CMP_BASE + ADDR_WIDTH'(i))  h = 1'b1;
        end
        return h;
    endfunction

    logic                  w_core;
    logic                  w_hacc;
    logic                  w_wen;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [1:0]            w_wcmd;
    logic [XLEN-1:0]       w_wdata;
    logic [XLEN-1:0]       w_hrd;
    logic [XLEN-1:0]       w_old;
    logic [XLEN-1:0]       w_wval;

    assign rdata  = f_read(addr);
    assign hit    = f_hit(addr);
    assign w_hrd  = f_read(host_req_addr);
    assign w_core = (cmd != 2'd0);

    assign host_req_ready  = (r_state == S_IDLE) && !w_core;
    assign host_resp_valid = (r_state == S_WAIT);
    assign host_resp_data  = r_resp_data;
    assign w_hacc          = host_req_valid && host_req_ready;

    // The host only gets the port when the core is idle
    assign w_wen   = w_core || (w_hacc && host_req_rw);
    assign w_waddr = w_core ? addr  : host_req_addr;
    assign w_wcmd  = w_core ? cmd   : 2'd1;
    assign w_wdata = w_core ? wdata : host_req_data;
    assign w_old   = w_core ? rdata : w_hrd;

    always_comb begin
        w_wval = w_wdata;
        unique case (w_wcmd)
            2'd2:    w_wval = w_old | w_wdata;
            2'd3:    w_wval = w_old & ~w_wdata;
            default: w_wval = w_wdata;
        endcase
    end

    logic                 w_ctrl_wr;
    logic                 w_pend_wr;
    logic                 w_ie_wr;
    logic [N_CNT-1:0]     w_lo_wr;
    logic [N_CNT-1:0]     w_hi_wr;
    logic [N_CNT-1:0]     w_cmp_wr;
    logic [N_CNT-1:0]     w_inc;
    logic [N_CNT-1:0]     w_mat;
    logic [N_CNT-1:0]     w_ovf;
    logic [CNT_WIDTH-1:0] w_cnt_p1 [N_CNT];
    logic [N_CNT-1:0]     w_pm_n;
    logic [N_CNT-1:0]     w_po_n;

    assign w_ctrl_wr = w_wen && (w_waddr == CTRL_ADDR);
    assign w_pend_wr = w_wen && (w_waddr == PEND_ADDR);
    assign w_ie_wr   = w_wen && (w_waddr == IE_ADDR);

    always_comb begin
        w_lo_wr  = '0;
        w_hi_wr  = '0;
        w_cmp_wr = '0;
        w_inc    = '0;
        w_mat    = '0;
        w_ovf    = '0;
        for (int i = 0; i < N_CNT; i++) begin
            w_cnt_p1[i] = r_cnt[i] + 1'b1;
            w_lo_wr[i]  = w_wen && (w_waddr == CNT_BASE + ADDR_WIDTH'(i));
            w_hi_wr[i]  = w_wen && (w_waddr == CNTH_BASE + ADDR_WIDTH'(i));
            w_cmp_wr[i] = w_wen && (w_waddr == CMP_BASE + ADDR_WIDTH'(i));
            // A software write to either half swallows that cycle's event
            w_inc[i] = event_inc[i] && !r_inh[i] && !w_lo_wr[i] && !w_hi_wr[i];
            w_mat[i] = w_inc[i] && (w_cnt_p1[i][XLEN-1:0] == r_cmp[i]);
            w_ovf[i] = w_inc[i] && (&r_cnt[i]);
        end
    end

    // Hardware sets are ORed in last so they beat any software clear
    always_comb begin
        w_pm_n = r_pm;
        w_po_n = r_po;
        if (w_pend_wr) begin
            w_pm_n = w_wval[N_CNT-1:0];
            w_po_n = w_wval[16 +: N_CNT];
        end
        w_pm_n = (w_pm_n & ~w_cmp_wr) | w_mat;
        w_po_n = w_po_n | w_ovf;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CNT; i++) begin
                r_cnt[i] <= '0;
                r_cmp[i] <= '1;
            end
            r_inh <= '1;
            r_pm  <= '0;
            r_po  <= '0;
            r_iem <= '0;
            r_ieo <= '0;
        end else begin
            for (int i = 0; i < N_CNT; i++) begin
                if (w_lo_wr[i])
                    r_cnt[i][XLEN-1:0] <= w_wval;
                else if (w_hi_wr[i])
                    r_cnt[i][CNT_WIDTH-1:XLEN] <= w_wval[HW-1:0];
                else if (w_inc[i])
                    r_cnt[i] <= w_cnt_p1[i];
                if (w_cmp_wr[i])
                    r_cmp[i] <= w_wval;
            end
            if (w_ctrl_wr)
                r_inh <= w_wval[N_CNT-1:0];
            if (w_ie_wr) begin
                r_iem <= w_wval[N_CNT-1:0];
                r_ieo <= w_wval[16 +: N_CNT];
            end
            r_pm <= w_pm_n;
            r_po <= w_po_n;
        end
    end

    assign irq     = (r_pm & r_iem) | (r_po & r_ieo);
    assign irq_any = |irq;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_resp_data <= '0;
        end else begin
            r_state <= w_state_n;
            if (w_hacc)
                r_resp_data <= w_hrd;
        end
    end

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            S_IDLE:  if (w_hacc) w_state_n = S_WAIT;
            S_WAIT:  if (host_resp_ready) w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_vscale_hpm_counter_bank.sv
// Directed scoreboard bench for vscale_hpm_counter_bank: stimulus queues
// expected values, a negedge monitor pops and compares them.
module tb_vscale_hpm_counter_bank;

    localparam logic [11:0] CNT0  = 12'hB00;
    localparam logic [11:0] CNTH0 = 12'hB80;
    localparam logic [11:0] CMP0  = 12'h7D0;
    localparam logic [11:0] CTRL  = 12'h7E0;
    localparam logic [11:0] PEND  = 12'h7E1;
    localparam logic [11:0] IE    = 12'h7E2;

    localparam int K_RD  = 0;
    localparam int K_IRQ = 1;
    localparam int K_RDY = 2;
    localparam int K_VLD = 3;
    localparam int K_HIT = 4;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] val;
    } exp_t;

    logic        clk = 0;
    logic        reset;
    logic [11:0] addr;
    logic [1:0]  cmd;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;
    logic [3:0]  event_inc;
    logic [3:0]  irq;
    logic        irq_any;
    logic        host_req_valid;
    logic        host_req_ready;
    logic        host_req_rw;
    logic [11:0] host_req_addr;
    logic [31:0] host_req_data;
    logic        host_resp_valid;
    logic        host_resp_ready;
    logic [31:0] host_resp_data;

    exp_t q_core[$];
    exp_t q_host[$];
    logic probe = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    vscale_hpm_counter_bank dut (
        .clk(clk), .reset(reset), .addr(addr), .cmd(cmd), .wdata(wdata),
        .rdata(rdata), .hit(hit), .event_inc(event_inc), .irq(irq),
        .irq_any(irq_any), .host_req_valid(host_req_valid),
        .host_req_ready(host_req_ready), .host_req_rw(host_req_rw),
        .host_req_addr(host_req_addr), .host_req_data(host_req_data),
        .host_resp_valid(host_resp_valid), .host_resp_ready(host_resp_ready),
        .host_resp_data(host_resp_data)
    );

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] obs;
        if (probe) begin
            checks++;
            if (q_core.size() == 0) begin
                failures++;
                $display("FAIL core_underflow got=none want=entry");
            end else begin
                e = q_core.pop_front();
                case (e.kind)
                    K_RD:    obs = rdata;
                    K_IRQ:   obs = {27'd0, irq_any, irq};
                    K_RDY:   obs = {31'd0, host_req_ready};
                    K_VLD:   obs = {31'd0, host_resp_valid};
                    default: obs = {31'd0, hit};
                endcase
                if (obs !== e.val) begin
                    failures++;
                    $display("FAIL %s got=%h want=%h", e.name, obs, e.val);
                end
            end
        end
        if (host_resp_valid && host_resp_ready) begin
            checks++;
            if (q_host.size() == 0) begin
                failures++;
                $display("FAIL host_unexpected got=%h want=none", host_resp_data);
            end else begin
                e = q_host.pop_front();
                if (host_resp_data !== e.val) begin
                    failures++;
                    $display("FAIL %s got=%h want=%h", e.name, host_resp_data, e.val);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input int kind, input string name, input logic [31:0] v);
        q_core.push_back('{name, kind, v});
        probe = 1;
        @(negedge clk);
        #1 probe = 0;
        step();
    endtask

    task automatic rd(input logic [11:0] a, input string name, input logic [31:0] v);
        addr = a;
        expect_now(K_RD, name, v);
    endtask

    task automatic cwr(input logic [11:0] a, input logic [1:0] c, input logic [31:0] d);
        addr = a; cmd = c; wdata = d;
        step();
        cmd = 2'd0;
    endtask

    task automatic inc(input logic [3:0] m, input int n);
        for (int k = 0; k < n; k++) begin
            event_inc = m;
            step();
        end
        event_inc = '0;
    endtask

    // irq_any rides in bit 4 of the irq observation
    function automatic logic [31:0] irqv(input logic [3:0] v);
        return {27'd0, |v, v};
    endfunction

    initial begin
        int n;
        reset = 1; addr = '0; cmd = '0; wdata = '0; event_inc = '0;
        host_req_valid = 0; host_req_rw = 0; host_req_addr = '0;
        host_req_data = '0; host_resp_ready = 0;
        repeat (3) step();
        reset = 0;

        rd(CTRL, "rst_ctrl", 32'h0000000F);
        rd(CMP0, "rst_cmp0", 32'hFFFFFFFF);
        rd(PEND, "rst_pend", 32'h0);
        expect_now(K_IRQ, "rst_irq", irqv(4'h0));
        expect_now(K_RDY, "rst_hready", 32'd1);
        expect_now(K_VLD, "rst_hvalid", 32'd0);

        addr = 12'h123;
        expect_now(K_HIT, "unmapped_hit", 32'd0);
        rd(12'h123, "unmapped_rd", 32'h0);
        addr = CNT0 + 12'd3;
        expect_now(K_HIT, "mapped_hit", 32'd1);

        cwr(CTRL, 2'd1, 32'h0);
        inc(4'b0001, 5);
        rd(CNT0, "t1_cnt0", 32'd5);
        rd(CNTH0, "t1_cnth0", 32'd0);

        cwr(CNTH0, 2'd1, 32'hFFFFFFFF);
        cwr(CNT0, 2'd1, 32'hFFFFFFFF);
        rd(CNTH0, "t2_cnth_ff", 32'hFFFFFFFF);
        inc(4'b0001, 1);
        rd(CNT0, "t2_cnt0_wrap", 32'd0);
        rd(CNTH0, "t2_cnth_wrap", 32'd0);
        rd(PEND, "t2_pend_ovf", 32'h00010000);
        expect_now(K_IRQ, "t2_irq_masked", irqv(4'h0));
        cwr(IE, 2'd2, 32'h00010000);
        expect_now(K_IRQ, "t2_irq_en", irqv(4'h1));
        cwr(PEND, 2'd3, 32'h00010000);
        expect_now(K_IRQ, "t2_irq_clr", irqv(4'h0));
        cwr(IE, 2'd1, 32'h0);

        cwr(CMP0 + 12'd1, 2'd1, 32'd3);
        cwr(IE, 2'd2, 32'h2);
        inc(4'b0010, 2);
        expect_now(K_IRQ, "t3_irq_pre", irqv(4'h0));
        inc(4'b0010, 1);
        expect_now(K_IRQ, "t3_irq_match", irqv(4'h2));
        cwr(CMP0 + 12'd1, 2'd1, 32'd3);
        expect_now(K_IRQ, "t3_irq_cmpwr", irqv(4'h0));
        repeat (4) step();
        expect_now(K_IRQ, "t3_irq_idle", irqv(4'h0));

        addr = CNT0 + 12'd2; cmd = 2'd1; wdata = 32'd10; event_inc = 4'b0100;
        step();
        cmd = 2'd0; event_inc = '0;
        rd(CNT0 + 12'd2, "t4_cnt2_wr", 32'd10);
        inc(4'b0100, 1);
        rd(CNT0 + 12'd2, "t4_cnt2_inc", 32'd11);

        // Host write contends with a core write, then wins once the core idles
        host_req_valid = 1; host_req_rw = 1; host_req_addr = CTRL;
        host_req_data = 32'h0;
        addr = CNT0 + 12'd3; cmd = 2'd1; wdata = 32'd7;
        expect_now(K_RDY, "t5_blocked", 32'd0);
        cmd = 2'd0;
        cwr(CTRL, 2'd1, 32'hF);
        cmd = 2'd1; addr = CNT0 + 12'd3;
        expect_now(K_RDY, "t5_blocked2", 32'd0);
        cmd = 2'd0;
        q_host.push_back('{"t5_resp_old_ctrl", 0, 32'h0000000F});
        expect_now(K_RDY, "t5_ready", 32'd1);
        host_req_valid = 0;
        for (int k = 0; k < 3; k++)
            expect_now(K_VLD, "t5_held", 32'd1);
        rd(CTRL, "t5_ctrl_written", 32'h0);
        host_resp_ready = 1;
        step();
        host_resp_ready = 0;
        expect_now(K_VLD, "t5_released", 32'd0);

        host_req_valid = 1; host_req_rw = 0; host_req_addr = CMP0 + 12'd1;
        n = 0;
        while (!host_req_ready && n < 20) begin
            step();
            n++;
        end
        if (n == 20) begin
            failures++;
            $display("FAIL host_rd_timeout got=blocked want=ready");
        end
        q_host.push_back('{"host_rd_cmp1", 0, 32'd3});
        step();
        host_req_valid = 0;
        host_resp_ready = 1;
        step();
        host_resp_ready = 0;

        cwr(CMP0, 2'd1, 32'd7);
        cwr(CNT0, 2'd1, 32'd6);
        cwr(PEND, 2'd1, 32'h1);
        addr = PEND; cmd = 2'd3; wdata = 32'h1; event_inc = 4'b0001;
        step();
        cmd = 2'd0; event_inc = '0;
        rd(PEND, "t6_match_wins", 32'h1);
        cwr(PEND, 2'd3, 32'h1);
        rd(PEND, "t6_clear", 32'h0);

        host_req_valid = 1; host_req_rw = 0; host_req_addr = CTRL;
        step();
        host_req_valid = 0;
        expect_now(K_VLD, "rst_mid_pre", 32'd1);
        reset = 1;
        step();
        reset = 0;
        expect_now(K_VLD, "rst_mid_vld", 32'd0);
        rd(CTRL, "rst_mid_ctrl", 32'h0000000F);
        rd(CMP0 + 12'd1, "rst_mid_cmp1", 32'hFFFFFFFF);

        if (q_core.size() != 0 || q_host.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d want=0", q_core.size() + q_host.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
